// File: rtl/seg7_step_counter_if.sv
// Board-side bundle of the step counter: switch inputs and display outputs.
// DIGITS must match the DIGITS parameter of the seg7_step_counter that uses it.
interface seg7_step_counter_if #(
   parameter int unsigned DIGITS = 4
);
   logic [0:2]          V_SW;   // [0] step, [1] direction (1 = down), [2] clear
   logic [0:7*DIGITS-1] HEX;    // active-low a..g per digit, digit 0 lowest field
   logic [4*DIGITS-1:0] COUNT;  // nibble i = digit i
   logic                WRAP;   // one-cycle rollover pulse

   // Board / stimulus side: drives the switches, watches the displays.
   modport master (
      output V_SW,
      input  HEX,
      input  COUNT,
      input  WRAP
   );

   // Counter side.
   modport slave (
      input  V_SW,
      output HEX,
      output COUNT,
      output WRAP
   );
endinterface

// File: rtl/seg7_step_counter.sv
// Multi-digit step counter with seven-segment outputs.
// The bouncy step switch is synchronised, debounced and rising-edge detected;
// each accepted press moves the count one step up or down, in hex or BCD.
// Clear is synchronous and overrides a step landing in the same cycle.
module seg7_step_counter #(
   parameter int unsigned DIGITS          = 4,       // 1..8
   parameter int unsigned MODE_BCD        = 0,       // 1 = digits count 0..9
   parameter int unsigned DEBOUNCE_CYCLES = 500000,  // minimum 1
   parameter int unsigned BLANK_LZ        = 0        // 1 = blank leading zeros
) (
   input  logic               CLOCK_50,
   input  logic               RST,
   seg7_step_counter_if.slave bus
);

   // dbc only ever holds 0..DEBOUNCE_CYCLES-1.
   localparam int unsigned    DBC_W     = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]     DIGIT_MAX = (MODE_BCD != 0) ? 4'd9 : 4'd15;

   // Active-low a..g pattern; the leftmost literal bit is segment a.
   function automatic logic [0:6] seg_decode(input logic [3:0] v);
      logic [0:6] seg;
      case (v)
         4'h0:    seg = 7'b0000001;
         4'h1:    seg = 7'b1001111;
         4'h2:    seg = 7'b0010010;
         4'h3:    seg = 7'b0000110;
         4'h4:    seg = 7'b1001100;
         4'h5:    seg = 7'b0100100;
         4'h6:    seg = 7'b0100000;
         4'h7:    seg = 7'b0001111;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0000100;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b1100000;
         4'hC:    seg = 7'b0110001;
         4'hD:    seg = 7'b1000010;
         4'hE:    seg = 7'b0110000;
         default: seg = 7'b0111000;
      endcase
      return seg;
   endfunction

   // Display image of a zero count, used as the HEX reset value.
   function automatic logic [0:7*DIGITS-1] hex_reset_value();
      logic [0:7*DIGITS-1] img;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if ((BLANK_LZ != 0) && (i > 0)) img[7*i +: 7] = 7'b1111111;
         else                             img[7*i +: 7] = seg_decode(4'h0);
      end
      return img;
   endfunction

   localparam logic [0:7*DIGITS-1] HEX_RST = hex_reset_value();

   // ---------------------------------------------------------------------
   // Switch synchronisers
   // ---------------------------------------------------------------------
   logic [2:0] sw_raw;
   logic [2:0] sw_s1;
   logic [2:0] sw_s2;
   logic       step_s2;
   logic       dir_s2;
   logic       clr_s2;

   // Re-pack the ascending V_SW bus so bit n of sw_raw is switch n.
   assign sw_raw  = {bus.V_SW[2], bus.V_SW[1], bus.V_SW[0]};
   assign step_s2 = sw_s2[0];
   assign dir_s2  = sw_s2[1];
   assign clr_s2  = sw_s2[2];

   // Two-flop synchroniser for all three switches; only s2 is used downstream.
   always_ff @(posedge CLOCK_50) begin
      // NOTE: sequential state is written with <= so every flop samples pre-edge values.
      if (RST) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         sw_s1 <= sw_raw;
         sw_s2 <= sw_s1;
      end
   end

   // ---------------------------------------------------------------------
   // Debounce and rising-edge detect of the step switch
   // ---------------------------------------------------------------------
   logic             db;
   logic             db_prev;
   logic [DBC_W-1:0] dbc;
   logic             step;

   // Accept a new level only after it differs from db for DEBOUNCE_CYCLES
   // consecutive cycles; any return to db restarts the count.
   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         db      <= 1'b0;
         db_prev <= 1'b0;
         dbc     <= '0;
      end else begin
         db_prev <= db;
         if (step_s2 == db) begin
            dbc <= '0;
         end else if (dbc == DBC_LAST) begin
            db  <= step_s2;
            dbc <= '0;
         end else begin
            dbc <= dbc + 1'b1;
         end
      end
   end

   // One step per accepted rising level; falling edges are ignored.
   assign step = db & ~db_prev;

   // ---------------------------------------------------------------------
   // Digit chain: next count for a single step in the current direction
   // ---------------------------------------------------------------------
   logic [4*DIGITS-1:0] count_q;
   logic [4*DIGITS-1:0] count_step;
   logic                wrap_q;
   logic                wrap_step;

   // Ripple a carry (up) or borrow (down) from digit 0; whatever survives past
   // the top digit is the rollover.
   always_comb begin : step_calc
      logic       carry;
      logic [3:0] d;
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      count_step = count_q;
      carry      = 1'b1;
      d          = 4'h0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         d = count_q[4*i +: 4];
         if (carry) begin
            if (!dir_s2) begin
               // Values above max (forced A..F in BCD) wrap like max.
               if (d >= DIGIT_MAX) begin
                  count_step[4*i +: 4] = 4'h0;
               end else begin
                  count_step[4*i +: 4] = d + 4'd1;
                  carry                = 1'b0;
               end
            end else begin
               if (d == 4'h0) begin
                  count_step[4*i +: 4] = DIGIT_MAX;
               end else begin
                  count_step[4*i +: 4] = d - 4'd1;
                  carry                = 1'b0;
               end
            end
         end
      end
      wrap_step = carry;
   end

   // Count register: reset, then clear, then step; WRAP only rides on a step.
   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else if (clr_s2) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else if (step) begin
         count_q <= count_step;
         wrap_q  <= wrap_step;
      end else begin
         wrap_q  <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Seven-segment decode with optional leading-zero blanking
   // ---------------------------------------------------------------------
   logic [0:7*DIGITS-1] hex_nxt;
   logic [0:7*DIGITS-1] hex_q;

   // Walk from the top digit down, tracking whether everything so far is zero.
   always_comb begin : hex_calc
      logic upper_zero;
      hex_nxt    = '1;
      upper_zero = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         upper_zero = upper_zero & (count_q[4*i +: 4] == 4'h0);
         if ((BLANK_LZ != 0) && (i > 0) && upper_zero) begin
            hex_nxt[7*i +: 7] = 7'b1111111;
         end else begin
            hex_nxt[7*i +: 7] = seg_decode(count_q[4*i +: 4]);
         end
      end
   end

   // Registered display, one cycle behind COUNT.
   always_ff @(posedge CLOCK_50) begin
      if (RST) hex_q <= HEX_RST;
      else     hex_q <= hex_nxt;
   end

   assign bus.COUNT = count_q;
   assign bus.WRAP  = wrap_q;
   assign bus.HEX   = hex_q;

endmodule
